delay_arbiter: RTL and testbench
================================

// Module: delay_arbiter
// PURPOSE
//  Shares one N-cycle delay timer between NREQ requesters. Round-robin grant; the winner owns the timer
//  until its delay expires or it withdraws. Sits between request sources and the single shared DELAY counter.
//  Emits a one-cycle done pulse to the owner and a sticky err flag for formal checking.
// PARAMETERS
//  NREQ   4       number of requesters (2..8)
//  N      400000  terminal count; timer runs cnt = 0..N inclusive (N+1 RUN cycles)
//  CBITS  19      counter width; must satisfy 2**CBITS > N+1
// PORTS
//  clk    input   1      single clock, rising edge
//  rst_n  input   1      asynchronous, active-low reset
//  req    input   NREQ   level request per requester; held until done or withdrawn
//  grant  output  NREQ   one-hot owner of timer; all zero when IDLE
//  done   output  NREQ   one-cycle pulse to owner when its delay expires
//  busy   output  1      timer owned (state RUN or DONE)
//  err    output  1      sticky: cnt observed > N, or grant not one-hot/zero
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0, grant=0, done=0, busy=0, err=0, rr_ptr=0.
//  FSM states IDLE, RUN, DONE:
//   IDLE: if |req: pick first set req at/after rr_ptr (wrap NREQ-1->0); next grant=onehot(winner),
//         cnt=0, ->RUN. Else stay.
//   RUN : if req[owner]==0 -> abort: grant=0, cnt=0, no done, ->IDLE, rr_ptr=owner+1.
//         elif cnt==N -> ->DONE. else cnt=cnt+1.
//   DONE: done[owner]=1 for this cycle only, grant still asserted; next: grant=0, cnt=0,
//         rr_ptr=owner+1 mod NREQ, ->IDLE.
//  Latency: req sampled in IDLE at cycle t -> grant visible t+1 -> done visible t+N+2 -> grant low t+N+3.
//  One IDLE bubble between consecutive grants (earliest regrant t+N+4 visible).
//  Requests from non-owners during RUN/DONE are ignored (not queued); they compete at next IDLE.
//  Owner dropping req in DONE cycle: done still pulses (expiry already reached).
//  cnt never exceeds N; cnt arithmetic unsigned CBITS wide, no wrap in correct operation.
//  err set when cnt>N or grant has >1 bit set; cleared only by reset.
//  Reset asserted mid-RUN: immediate return to reset values; no done issued.
//  busy = (state != IDLE); done and grant are registered outputs.
// CONFIGURATION
//  DELAY_ARB_PROPS_EN defined: module compiles embedded concurrent properties:
//   p_safe : nexttime always err==0
//   p_live : for each i, (always s_eventually !rst_n) or (always s_eventually done[i]) under
//            fairness (always req[i] kept until done[i]); p_onehot: $onehot0(grant).
//  Not defined: no properties compiled; RTL behaviour identical in both cases.
// STRUCTURE
//  Package delay_arb_pkg: state_t enum {IDLE,RUN,DONE}, default N/CBITS/NREQ constants,
//   function next_rr(ptr, req) returning winner index.
//  Sub-module rr_pick (combinational round-robin selector: req, rr_ptr -> onehot winner, valid).
//  Top: FSM, counter, owner index register, err logic, optional properties.
// TESTING (bench with N=5, CBITS=3, NREQ=4)
//  Single req[2]=1 from t=0 -> grant=4'b0100 at t=1, done[2]=1 only at t=7, grant=0 at t=8.
//  req=4'b1111 held -> grants 0,1,2,3,0 in order; each done spaced 8 cycles; never two bits set.
//  req[1] drops at cnt=3 in RUN -> next cycle IDLE, grant=0, done stays 0, next winner req[2..].
//  rst_n pulsed low at cnt=2 -> grant/done/busy/cnt=0 same cycle (async); restart from rr_ptr=0.
//  req=0 always -> state IDLE, busy=0, err=0 for 100 cycles.
//  With DELAY_ARB_PROPS_EN: formal run proves p_safe, p_onehot and p_live for all i.

Source files
------------

// File: rtl/delay_arb_pkg.sv
// Shared types, defaults and round-robin helper for delay_arbiter.
// Supports up to MAX_REQ requesters; indices are 3 bits wide.
package delay_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_N     = 400000;
  localparam int DEF_CBITS = 19;
  localparam int MAX_REQ   = 8;

  // First set request at or after ptr, wrapping at nreq.
  // Returns ptr when no request is set.
  function automatic logic [2:0] next_rr(
    input logic [2:0] ptr,
    input logic [7:0] req,
    input int         nreq
  );
    logic [2:0] w;
    logic       f;
    int         idx;
    w = ptr;
    f = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!f && (k < nreq) && req[idx[2:0]]) begin
        w = idx[2:0];
        f = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/delay_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports: i_req, i_ptr in; o_onehot, o_idx, o_valid out.
module rr_pick
  import delay_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [2:0]      o_idx,
  output logic            o_valid
);

  logic [7:0] w_req8;

  always_comb begin
    w_req8 = '0;
    w_req8[NREQ-1:0] = i_req;
  end

  assign o_valid  = |i_req;
  assign o_idx    = next_rr(i_ptr, w_req8, NREQ);
  assign o_onehot = o_valid ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin owner of one shared N-cycle delay timer.
// Ports: clk, rst_n, req in; grant, done, busy, err out. Macro: DELAY_ARB_PROPS_EN.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int N     = DEF_N,
  parameter int CBITS = DEF_CBITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            err
);

  state_t            r_state;
  logic [CBITS-1:0]  r_cnt;
  logic [2:0]        r_owner;
  logic [2:0]        r_rr_ptr;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_done;
  logic              r_err;

  logic [7:0]        w_req8;
  logic [NREQ-1:0]   w_pick;
  logic [2:0]        w_win;
  logic              w_valid;
  logic [2:0]        w_nxt;
  logic              w_bad;

  always_comb begin
    w_req8 = '0;
    w_req8[NREQ-1:0] = req;
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick),
    .o_idx    (w_win),
    .o_valid  (w_valid)
  );

  assign w_nxt = (r_owner == 3'(NREQ-1)) ? 3'd0
                                         : r_owner + 3'd1;

  // Overrun of the terminal count or more than one grant bit.
  assign w_bad = (r_cnt > CBITS'(N)) |
                 (|(r_grant & (r_grant - NREQ'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= '0;
      r_err  <= r_err | w_bad;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant <= w_pick;
            r_owner <= w_win;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!w_req8[r_owner]) begin
            r_grant  <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= w_nxt;
            r_state  <= IDLE;
          end else if (r_cnt == CBITS'(N)) begin
            // done pulses during the DONE cycle
            r_done  <= r_grant;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CBITS'(1);
          end
        end
        DONE: begin
          r_grant  <= '0;
          r_cnt    <= '0;
          r_rr_ptr <= w_nxt;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);
  assign err   = r_err;

`ifdef DELAY_ARB_PROPS_EN
  p_safe: assert property (
    @(posedge clk) disable iff (!rst_n) ##1 !err);

  p_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(grant));

  for (genvar i = 0; i < NREQ; i++) begin : g_live
    f_hold: assume property (
      @(posedge clk) disable iff (!rst_n)
      req[i] && !done[i] |=> req[i]);
    p_live: assert property (
      @(posedge clk) disable iff (!rst_n)
      req[i] |-> s_eventually done[i]);
  end
`endif

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter, N=5 CBITS=3 NREQ=4.
// Outputs sampled 1ns after each rising edge.
module tb_delay_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] done;
  logic       busy;
  logic       err;

  int n_vec;
  int n_err;

  delay_arbiter #(
    .NREQ  (4),
    .N     (5),
    .CBITS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] eg;
    logic [3:0] ed;
    int p;
    int j;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;

    // reset state
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_err",   32'(err),   32'h0);

    // single requester 2: grant t1..t7, done t7, low t8
    do_reset();
    req = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      eg = (k <= 7) ? 4'b0100 : 4'b0000;
      ed = (k == 7) ? 4'b0100 : 4'b0000;
      tick();
      check($sformatf("single_grant_t%0d", k), 32'(grant), 32'(eg));
      check($sformatf("single_done_t%0d", k),  32'(done),  32'(ed));
    end
    check("single_busy_t8", 32'(busy), 32'h0);

    // all requesting: owners 0,1,2,3,0 with 8-cycle period
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 40; k++) begin
      p = (k - 1) % 8;
      j = (k - 1) / 8;
      eg = (p <= 6) ? 4'(1 << (j % 4)) : 4'b0000;
      ed = (p == 6) ? 4'(1 << (j % 4)) : 4'b0000;
      tick();
      check($sformatf("rr_grant_t%0d", k), 32'(grant), 32'(eg));
      check($sformatf("rr_done_t%0d", k),  32'(done),  32'(ed));
    end
    check("rr_err", 32'(err), 32'h0);

    // owner 1 withdraws at cnt=3; next winner from ptr 2
    do_reset();
    req = 4'b0110;
    tick();
    check("ab_grant1", 32'(grant), 32'h2);
    tick();
    tick();
    tick();
    check("ab_grant_cnt3", 32'(grant), 32'h2);
    req = 4'b0101;
    tick();
    check("ab_grant_idle", 32'(grant), 32'h0);
    check("ab_done_idle",  32'(done),  32'h0);
    check("ab_busy_idle",  32'(busy),  32'h0);
    tick();
    check("ab_next_grant", 32'(grant), 32'h4);

    // async reset mid-run restores rr_ptr to 0
    do_reset();
    req = 4'b0010;
    tick();
    check("ar_g1", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();
    check("ar_abort", 32'(grant), 32'h0);
    req = 4'b1010;
    tick();
    check("ar_g3", 32'(grant), 32'h8);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("ar_grant_async", 32'(grant), 32'h0);
    check("ar_busy_async",  32'(busy),  32'h0);
    check("ar_done_async",  32'(done),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_restart", 32'(grant), 32'h2);
    for (int k = 0; k < 6; k++) tick();
    check("ar_no_stale_done", 32'(done), 32'h2);

    // no requests: stays idle
    do_reset();
    for (int k = 0; k < 100; k++) begin
      tick();
      check("idle_state", 32'({busy, err, grant, done}), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
